// File: rtl/bcd_time_of_day_counter.sv
// BCD hh:mm:ss time-of-day counter with 12h/24h mode, per-field load with
// validation and a registered load-error pulse.
// Optional alarm (AW/AEN/ALARM ports, alarm registers) enabled by ALARM_EN.
module bcd_time_of_day_counter #(
  parameter bit         HOUR_12 = 1'b0,
  parameter logic [7:0] SEC_RST = 8'h00,
  parameter logic [7:0] MIN_RST = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        L,
  input  logic [1:0]  sel,
  input  logic [7:0]  DI,
`ifdef ALARM_EN
  input  logic        AW,
  input  logic        AEN,
  output logic        ALARM,
`endif
  output logic [7:0]  QS,
  output logic [7:0]  QM,
  output logic [7:0]  QH,
  output logic [23:0] QHMS,
  output logic        PM,
  output logic        CO,
  output logic        LERR
);

  localparam logic [7:0] HOUR_RST = HOUR_12 ? 8'h12 : 8'h00;

  logic [7:0] sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic       pm_q, pm_d, lerr_q, lerr_d;
  logic [7:0] sec_inc, min_inc, hr_inc;
  logic       pm_inc, sec_carry, min_carry;
  logic       load_ok, aw_err;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic valid_ms(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic valid_hr(input logic [7:0] v);
    if (HOUR_12)
      return ((v[7:4] == 4'd0) && (v[3:0] >= 4'd1) && (v[3:0] <= 4'd9)) ||
             ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2));
    else
      return (v[3:0] <= 4'd9) &&
             ((v[7:4] <= 4'd1) || ((v[7:4] == 4'd2) && (v[3:0] <= 4'd3)));
  endfunction

  // Validity of DI for the field selected by sel
  always_comb begin
    load_ok = 1'b0;
    case (sel)
      2'd0, 2'd1: load_ok = valid_ms(DI);
      2'd2:       load_ok = valid_hr(DI);
      default:    load_ok = HOUR_12;
    endcase
  end

  // Single-step successor of the whole time value; all carries resolve in one cycle
  always_comb begin
    sec_carry = (sec_q == 8'h59);
    min_carry = (min_q == 8'h59);
    sec_inc   = sec_carry ? '0 : bcd_inc(sec_q);
    min_inc   = min_carry ? '0 : bcd_inc(min_q);
    hr_inc    = bcd_inc(hr_q);
    pm_inc    = pm_q;
    if (HOUR_12) begin
      if (hr_q == 8'h12) begin
        hr_inc = 8'h01;
      end else if (hr_q == 8'h11) begin
        hr_inc = 8'h12;
        pm_inc = ~pm_q;
      end
    end else if (hr_q == 8'h23) begin
      hr_inc = '0;
    end
  end

  // Next state: load has priority over count; a ce tick in a load cycle is dropped
  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hr_d   = hr_q;
    pm_d   = pm_q;
    lerr_d = aw_err;
    if (L) begin
      lerr_d = ~load_ok;
      if (load_ok) begin
        case (sel)
          2'd0:    sec_d = DI;
          2'd1:    min_d = DI;
          2'd2:    hr_d  = DI;
          default: pm_d  = DI[0];
        endcase
      end
    end else if (ce) begin
      sec_d = sec_inc;
      if (sec_carry) min_d = min_inc;
      if (sec_carry && min_carry) begin
        hr_d = hr_inc;
        pm_d = pm_inc;
      end
    end
  end

  // Time registers and load-error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q  <= SEC_RST;
      min_q  <= MIN_RST;
      hr_q   <= HOUR_RST;
      pm_q   <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      sec_q  <= sec_d;
      min_q  <= min_d;
      hr_q   <= hr_d;
      pm_q   <= pm_d;
      lerr_q <= lerr_d;
    end
  end

`ifdef ALARM_EN
  logic [7:0] amin_q, amin_d, ahr_q, ahr_d;
  logic       apm_q, apm_d, alarm_q, alarm_d, aw_ok;

  // Alarm field writes and match detection on the value a ce step produces
  always_comb begin
    amin_d = amin_q;
    ahr_d  = ahr_q;
    apm_d  = apm_q;
    aw_ok  = (sel != 2'd0) && load_ok;
    aw_err = ~L & AW & ~aw_ok;
    if (!L && AW && aw_ok) begin
      case (sel)
        2'd1:    amin_d = DI;
        2'd2:    ahr_d  = DI;
        default: apm_d  = DI[0];
      endcase
    end
    alarm_d = ~L & ce & AEN & (sec_d == 8'h00) & (min_d == amin_q) &
              (hr_d == ahr_q) & (!HOUR_12 || (pm_d == apm_q));
  end

  // Alarm registers and registered alarm pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amin_q  <= '0;
      ahr_q   <= '0;
      apm_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      amin_q  <= amin_d;
      ahr_q   <= ahr_d;
      apm_q   <= apm_d;
      alarm_q <= alarm_d;
    end
  end

  assign ALARM = alarm_q;
`else
  assign aw_err = 1'b0;
`endif

  assign QS   = sec_q;
  assign QM   = min_q;
  assign QH   = hr_q;
  assign QHMS = {hr_q, min_q, sec_q};
  assign PM   = HOUR_12 ? pm_q : 1'b0;
  assign LERR = lerr_q;
  assign CO   = ce & ~L & (HOUR_12 ? (({hr_q, min_q, sec_q} == 24'h115959) & pm_q)
                                   : ({hr_q, min_q, sec_q} == 24'h235959));

endmodule
